// File: rtl/seg_p2s_shifter.sv
// seg_p2s_shifter
//   Parallel-to-serial output stage for the 8-digit seven-segment display.
//   Takes a 64-bit segment pattern (digit 7 in [63:56]) and shifts it MSB
//   first into a 74HC164 chain. The chain is cleared first, then each bit is
//   presented for CLK_DIV cycles with sclk low and CLK_DIV cycles with sclk
//   high; the chain samples on the sclk rising edge.
//
// Parameters
//   CLK_DIV   : system-clock cycles per serial half period (1..255)
//   DATA_BITS : bits per frame (64 for the display chain)
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   frame request, sampled only while idle
//   par_data in   segment pattern, captured when a frame is accepted
//   busy     out  high from the first CLR cycle through the DONE cycle
//   done     out  one-cycle pulse in the final frame cycle
//   sdata    out  serial data, changes only on entry to a low phase
//   sclk     out  serial shift clock
//   sclr_n   out  active-low chain clear
//
// Optional feature (macro SEG_P2S_AUTO_REFRESH_EN)
//   When defined, a snapshot of the last accepted pattern is kept and the
//   block self-starts from idle whenever par_data differs from it.
//
// All outputs are registered: their next values are decoded from the next
// state, so each output lines up with the state it belongs to and there is
// no combinational path from the inputs.

module seg_p2s_shifter #(
  parameter int CLK_DIV   = 2,
  parameter int DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] par_data,
  output logic                 busy,
  output logic                 done,
  output logic                 sdata,
  output logic                 sclk,
  output logic                 sclr_n
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] BITS_END = 7'(DATA_BITS);

  state_t               state, state_n;
  logic [7:0]           div_cnt, div_cnt_n;
  logic [6:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 busy_n, done_n, sdata_n, sclk_n, sclr_n_n;
  logic                 div_last;
  logic                 req;

`ifdef SEG_P2S_AUTO_REFRESH_EN
  logic [DATA_BITS-1:0] snap, snap_n;

  // A pattern change from the encoder behaves like an explicit request.
  assign req = start | (par_data != snap);
`else
  assign req = start;
`endif

  assign div_last = (div_cnt == DIV_LAST);

  // Next-state, datapath and next-output decode
  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt + 8'd1;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
`ifdef SEG_P2S_AUTO_REFRESH_EN
    snap_n    = snap;
`endif

    case (state)
      S_IDLE: begin
        if (req) begin
          shreg_n   = par_data;
          bit_cnt_n = 7'd0;
`ifdef SEG_P2S_AUTO_REFRESH_EN
          snap_n    = par_data;
`endif
          state_n   = S_CLR;
        end
      end
      S_CLR: begin
        if (div_last) state_n = S_LO;
      end
      S_LO: begin
        if (div_last) state_n = S_HI;
      end
      S_HI: begin
        if (div_last) begin
          shreg_n   = {shreg[DATA_BITS-2:0], 1'b0};
          bit_cnt_n = (bit_cnt == BITS_END) ? bit_cnt : bit_cnt + 7'd1;
          state_n   = (bit_cnt_n == BITS_END) ? S_DONE : S_LO;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Each phase is timed from zero; idle holds the divider at zero.
    if (state_n != state || state == S_IDLE) div_cnt_n = 8'd0;

    busy_n   = (state_n != S_IDLE);
    done_n   = (state_n == S_DONE);
    sclk_n   = (state_n == S_HI);
    sclr_n_n = (state_n != S_CLR);

    // Data only moves on entry to a low phase, giving a full half period of
    // setup and hold around every sclk rising edge.
    sdata_n = sdata;
    if (state_n == S_LO && state != S_LO) sdata_n = shreg_n[DATA_BITS-1];
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      div_cnt <= 8'd0;
      bit_cnt <= 7'd0;
      shreg   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sdata   <= 1'b0;
      sclk    <= 1'b0;
      sclr_n  <= 1'b1;
    end else begin
      state   <= state_n;
      div_cnt <= div_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      busy    <= busy_n;
      done    <= done_n;
      sdata   <= sdata_n;
      sclk    <= sclk_n;
      sclr_n  <= sclr_n_n;
    end
  end

`ifdef SEG_P2S_AUTO_REFRESH_EN
  always_ff @(posedge clk) begin
    if (rst) snap <= '0;
    else     snap <= snap_n;
  end
`endif

endmodule

// File: tb/tb_seg_p2s_shifter.sv
// Testbench for seg_p2s_shifter. Two instances: u0 with CLK_DIV=2 and u1
// with CLK_DIV=1. Stimulus pushes expected serial bits and expected frame
// shapes into queues; one monitor samples on the falling edge and checks
// each sclk rising edge, clear length, busy length and done spacing.

module tb_seg_p2s_shifter;

  localparam int DIV0 = 2;
  localparam int DIV1 = 1;

  localparam logic [63:0] PAT1 = 64'hFFFF_0000_A5A5_0001;
  localparam logic [63:0] PAT2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PAT3 = 64'hDEAD_BEEF_0F0F_F0F0;
  localparam logic [63:0] PAT4 = 64'h8000_0000_0000_0001;
  localparam logic [63:0] PATB = 64'hC3C3_5A5A_0000_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1;
  logic [63:0] pd0, pd1;
  logic        busy0, done0, sdata0, sclk0, sclr0;
  logic        busy1, done1, sdata1, sclk1, sclr1;

  seg_p2s_shifter #(.CLK_DIV(DIV0), .DATA_BITS(64)) u0 (
    .clk(clk), .rst(rst), .start(start0), .par_data(pd0),
    .busy(busy0), .done(done0), .sdata(sdata0), .sclk(sclk0), .sclr_n(sclr0)
  );

  seg_p2s_shifter #(.CLK_DIV(DIV1), .DATA_BITS(64)) u1 (
    .clk(clk), .rst(rst), .start(start1), .par_data(pd1),
    .busy(busy1), .done(done1), .sdata(sdata1), .sclk(sclk1), .sclr_n(sclr1)
  );

  logic [1:0] busy_w, done_w, sdata_w, sclk_w, sclr_w;
  assign busy_w  = {busy1, busy0};
  assign done_w  = {done1, done0};
  assign sdata_w = {sdata1, sdata0};
  assign sclk_w  = {sclk1, sclk0};
  assign sclr_w  = {sclr1, sclr0};

  typedef struct {
    int len;  // busy cycles including the done cycle
    int gap;  // cycles since previous done, 0 = unchecked
  } frm_t;

  bit   exp_bits[$];
  frm_t exp_frm[$];

  logic [1:0] chk_idle, chk_busy;
  logic       fin;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  function automatic void chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d want %0d at cycle %0d", nm, act, req, cyc);
  endfunction

  task automatic push_frame(input logic [63:0] d, input int div, input int gap);
    frm_t f;
    for (int b = 63; b >= 0; b--) exp_bits.push_back(d[b]);
    f.len = 129 * div + 1;
    f.gap = gap;
    exp_frm.push_back(f);
  endtask

  // Monitor / scoreboard
  int   busy_cnt[2];
  int   clr_cnt[2];
  int   last_done[2];
  logic prev_sclk[2];
  logic prev_sdata[2];
  logic prev_sclr[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0; clr_cnt[i] = 0; last_done[i] = 0;
      prev_sclk[i] = 1'b0; prev_sdata[i] = 1'b0; prev_sclr[i] = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit   b;
    frm_t f;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy_cnt[i] = 0;
        clr_cnt[i]  = 0;
      end else begin
        if (chk_idle[i])
          chk("idle_outs", longint'({busy_w[i], done_w[i], sclk_w[i], sclr_w[i], sdata_w[i]}),
              longint'(5'b00010));
        if (chk_busy[i]) chk("auto_start_busy", longint'(busy_w[i]), 1);
        if (sclk_w[i] && !prev_sclk[i]) begin
          chk("sclk_expected", longint'(exp_bits.size() > 0), 1);
          if (exp_bits.size() > 0) begin
            b = exp_bits.pop_front();
            chk("serial_bit", longint'(sdata_w[i]), longint'(b));
          end
        end
        if (sclk_w[i]) chk("sdata_hold", longint'(sdata_w[i]), longint'(prev_sdata[i]));
        if (!sclr_w[i]) clr_cnt[i]++;
        else if (!prev_sclr[i]) begin
          chk("clr_len", clr_cnt[i], (i == 0) ? DIV0 : DIV1);
          clr_cnt[i] = 0;
        end
        if (busy_w[i]) busy_cnt[i]++;
        if (done_w[i]) begin
          chk("done_expected", longint'(exp_frm.size() > 0), 1);
          if (exp_frm.size() > 0) begin
            f = exp_frm.pop_front();
            chk("busy_len", busy_cnt[i], f.len);
            if (f.gap != 0) chk("done_gap", cyc - last_done[i], f.gap);
          end
          last_done[i] = cyc;
        end
        if (!busy_w[i]) busy_cnt[i] = 0;
      end
      prev_sclk[i]  = sclk_w[i];
      prev_sdata[i] = sdata_w[i];
      prev_sclr[i]  = sclr_w[i];
    end
    if (fin || cyc > 60000) begin
      if (!fin) $display("FAIL watchdog: got cycle %0d want end before 60000", cyc);
      chk("bits_left", exp_bits.size(), 0);
      chk("frames_left", exp_frm.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    pd0 = '0; pd1 = '0;
    chk_idle = 2'b00; chk_busy = 2'b00; fin = 1'b0;

    // Reset for two cycles, then idle for 20 with reset outputs
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_idle = 2'b11;
    repeat (20) @(posedge clk);
    #1 chk_idle = 2'b00;

    // Single frame, CLK_DIV=2
    push_frame(PAT1, DIV0, 0);
    pd0 = PAT1; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (270) @(posedge clk);

    // Start pulse and data change at bit 10 must not disturb the frame
    #1 push_frame(PAT2, DIV0, 0);
    pd0 = PAT2; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (43) @(posedge clk);
    #1 start0 = 1'b1; pd0 = '0;
`ifdef SEG_P2S_AUTO_REFRESH_EN
    // The data change leaves a refresh pending once the frame completes.
    push_frame(64'h0, DIV0, 0);
`endif
    @(posedge clk); #1 start0 = 1'b0;
`ifdef SEG_P2S_AUTO_REFRESH_EN
    repeat (560) @(posedge clk);
`else
    repeat (260) @(posedge clk);
`endif

    // Reset at bit 30 aborts the frame with no done
    #1 push_frame(PAT3, DIV0, 0);
    pd0 = PAT3; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (122) @(posedge clk);
    #1 rst = 1'b1; pd0 = '0;
    @(posedge clk);
    #1 rst = 1'b0; chk_idle = 2'b11;
    exp_bits.delete();
    exp_frm.delete();
    @(posedge clk); #1 chk_idle = 2'b00;
    repeat (5) @(posedge clk);

    // Full frame after the abort
    #1 push_frame(PAT4, DIV0, 0);
    pd0 = PAT4; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (270) @(posedge clk);

    // Back-to-back frames, CLK_DIV=1, start held across three accepts
    #1 push_frame(PATB, DIV1, 0);
    push_frame(PATB, DIV1, 131);
    push_frame(PATB, DIV1, 131);
    pd1 = PATB; start1 = 1'b1;
    repeat (300) @(posedge clk);
    #1 start1 = 1'b0;
    repeat (150) @(posedge clk);

`ifdef SEG_P2S_AUTO_REFRESH_EN
    // Data change alone starts a frame on the next edge
    #1 push_frame(64'h1, DIV0, 0);
    pd0 = 64'h1;
    @(posedge clk); #1 chk_busy = 2'b01;
    @(posedge clk); #1 chk_busy = 2'b00;
    repeat (400) @(posedge clk);
    #1 push_frame(64'h2, DIV0, 0);
    pd0 = 64'h2;
    repeat (400) @(posedge clk);
`endif

    #1 fin = 1'b1;
    repeat (5) @(posedge clk);
  end

endmodule
